md_unit: RTL and testbench

Parametrised multiply/divide unit for the E stage of the five-stage pipeline. It is the successor to the fixed 32-bit unit, with the following changes:
- configurable data width and per-class latencies;
- multiply-accumulate/subtract operations;
- a flush input that aborts an in-flight operation;
- fully defined divide-by-zero and overflow results.

The core stalls F/D and bubbles D/E while `start` or `busy` is high. HI/LO are read combinationally by the E stage.

---
 rtl/md_unit.sv | 160 ++++++++++++++++
 tb/tb_md_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers for the E stage.
// Compute ops run for a parameterised number of cycles; MTHI/MTLO and flush act immediately.
module md_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam int unsigned W2      = 2 * WIDTH;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               signed_op;
  logic [W2-1:0]      ext_a, ext_b, prod, acc, res;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b, div_b, q_mag, r_mag, quo, rem;

  // Result datapath, combinational on the latched operands
  always_comb begin
    signed_op = (op_q == OP_MULT) || (op_q == OP_DIV) ||
                (op_q == OP_MADD) || (op_q == OP_MSUB);
    ext_a = signed_op ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b = signed_op ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod  = ext_a * ext_b;
    acc   = {hi_q, lo_q};

    // Sign-magnitude divide; the most-negative / -1 case falls out as quo = a, rem = 0
    a_neg = signed_op & a_q[WIDTH-1];
    b_neg = signed_op & b_q[WIDTH-1];
    abs_a = a_neg ? WIDTH'(0) - a_q : a_q;
    abs_b = b_neg ? WIDTH'(0) - b_q : b_q;
    div_b = (b_q == '0) ? WIDTH'(1) : abs_b;
    q_mag = abs_a / div_b;
    r_mag = abs_a % div_b;
    quo   = (a_neg ^ b_neg) ? WIDTH'(0) - q_mag : q_mag;
    rem   = a_neg ? WIDTH'(0) - r_mag : r_mag;
    if (b_q == '0) begin
      quo = '1;
      rem = a_q;
    end

    unique case (op_q)
      OP_MULT, OP_MULTU: res = prod;
      OP_MADD, OP_MADDU: res = acc + prod;
      OP_MSUB, OP_MSUBU: res = acc - prod;
      OP_DIV,  OP_DIVU:  res = {rem, quo};
      default:           res = acc;
    endcase
  end

  // Next-state and HI/LO update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          unique case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              op_d    = op;
              a_d     = a;
              b_d     = b;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = op;
              a_d     = a;
              b_d     = b;
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = S_RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          hi_d    = res[W2-1:WIDTH];
          lo_d    = res[WIDTH-1:0];
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a default 32-bit instance and an 8-bit single-cycle instance.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, flush;
  logic [3:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy;

  logic        s_start, s_flush;
  logic [3:0]  s_op;
  logic [7:0]  s_a, s_b, s_hi, s_lo;
  logic        s_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  md_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .hi(hi), .lo(lo)
  );

  md_unit #(.WIDTH(8), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut8 (
    .clk(clk), .reset(reset), .start(s_start), .op(s_op), .a(s_a), .b(s_b),
    .flush(s_flush), .busy(s_busy), .hi(s_hi), .lo(s_lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Counts busy cycles at negedges until idle; 200 means the bound expired
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Issue one op on the 32-bit instance and wait for completion
  task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int n);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    wait_idle(n);
  endtask

  task automatic do_op8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int n);
    s_start = 1'b1; s_op = o; s_a = x; s_b = y;
    @(negedge clk);
    s_start = 1'b0;
    n = 0;
    while (s_busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 4'd0; a = '0; b = '0;
    s_start = 1'b0; s_flush = 1'b0; s_op = 4'd0; s_a = '0; s_b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);

    do_op(4'd0, 32'hFFFF_FFFF, 32'd2, n);
    check("mult_cycles", 64'(n), 64'd5);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFFE);

    do_op(4'd1, 32'hFFFF_FFFF, 32'd2, n);
    check("multu_cycles", 64'(n), 64'd5);
    check("multu_hi", 64'(hi), 64'h1);
    check("multu_lo", 64'(lo), 64'hFFFF_FFFE);

    do_op(4'd2, 32'hFFFF_FFF9, 32'd2, n);
    check("div_cycles", 64'(n), 64'd10);
    check("div_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(hi), 64'hFFFF_FFFF);

    do_op(4'd3, 32'd7, 32'd0, n);
    check("divu0_lo", 64'(lo), 64'hFFFF_FFFF);
    check("divu0_hi", 64'(hi), 64'd7);

    do_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check("divovf_lo", 64'(lo), 64'h8000_0000);
    check("divovf_hi", 64'(hi), 64'd0);

    do_op(4'd4, 32'd1, 32'd0, n);
    check("mthi_cycles", 64'(n), 64'd0);
    check("mthi_hi", 64'(hi), 64'd1);
    do_op(4'd5, 32'hFFFF_FFFF, 32'd0, n);
    check("mtlo_lo", 64'(lo), 64'hFFFF_FFFF);

    do_op(4'd7, 32'd1, 32'd1, n);
    check("maddu_cycles", 64'(n), 64'd5);
    check("maddu_hi", 64'(hi), 64'd2);
    check("maddu_lo", 64'(lo), 64'd0);

    do_op(4'd8, 32'd1, 32'd1, n);
    check("msub_hi", 64'(hi), 64'd1);
    check("msub_lo", 64'(lo), 64'hFFFF_FFFF);

    // MTHI while busy is ignored
    start = 1'b1; op = 4'd0; a = 32'd3; b = 32'd4;
    @(negedge clk);
    op = 4'd4; a = 32'hDEAD;
    @(negedge clk);
    start = 1'b0;
    check("mthi_busy_hi", 64'(hi), 64'd1);
    wait_idle(n);
    check("mult34_hi", 64'(hi), 64'd0);
    check("mult34_lo", 64'(lo), 64'd12);

    // Flush during busy cycle 3
    start = 1'b1; op = 4'd0; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush3_busy", 64'(busy), 64'd0);
    repeat (8) @(negedge clk);
    check("flush3_hi", 64'(hi), 64'd0);
    check("flush3_lo", 64'(lo), 64'd12);

    // Flush on the completion edge
    start = 1'b1; op = 4'd0; a = 32'd6; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("flush5_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush5_busy", 64'(busy), 64'd0);
    check("flush5_lo", 64'(lo), 64'd12);

    // Flush with start in idle drops the start
    start = 1'b1; flush = 1'b1; op = 4'd0; a = 32'd7; b = 32'd7;
    @(negedge clk);
    check("flush_start_busy", 64'(busy), 64'd0);
    op = 4'd4; a = 32'h55;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_mthi_hi", 64'(hi), 64'd0);

    do_op(4'd12, 32'h1234, 32'h5678, n);
    check("noop_busy", 64'(n), 64'd0);
    check("noop_lo", 64'(lo), 64'd12);

    // Reset mid-DIV discards the op
    start = 1'b1; op = 4'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_div_busy", 64'(busy), 64'd0);
    check("rst_div_lo", 64'(lo), 64'd0);
    repeat (15) @(negedge clk);
    check("rst_div_lo_late", 64'(lo), 64'd0);
    check("rst_div_hi_late", 64'(hi), 64'd0);

    // 8-bit, single-cycle instance
    do_op8(4'd2, 8'h80, 8'hFF, n);
    check("w8_div_cycles", 64'(n), 64'd1);
    check("w8_div_lo", 64'(s_lo), 64'h80);
    check("w8_div_hi", 64'(s_hi), 64'h00);
    do_op8(4'd1, 8'hFF, 8'hFF, n);
    check("w8_multu_cycles", 64'(n), 64'd1);
    check("w8_multu_hi", 64'(s_hi), 64'hFE);
    check("w8_multu_lo", 64'(s_lo), 64'h01);
    do_op8(4'd0, 8'hFF, 8'hFF, n);
    check("w8_mult_hi", 64'(s_hi), 64'h00);
    check("w8_mult_lo", 64'(s_lo), 64'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
